// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage plus the 32x32 architectural register file.
//
// Formats the writeback value (ALU result or a sub-word-extracted load) and
// commits it on the rising edge of Clk. It also serves two combinational
// decode read ports with write-through bypass.
//
// Ports:
//   Clk          pipeline clock; commits happen on the rising edge
//   Reset        asynchronous active-low reset; clears the file, reg[29] = SP_INIT
//   WBMemtoReg   1 = write formatted load data, 0 = write WBResult
//   WBRegWrite   write enable for this cycle's writeback
//   WBType       load format: 1 lb, 2 lbu, 3 lh, 4 lhu, others = full word
//   WBWriteReg   destination register index
//   WBResult     ALU result; [1:0] is the byte address for loads
//   WBReadDM     raw data-memory word
//   ReadReg1/2   read port indices
//   ReadData1/2  read port data (combinational, bypassed)
//   WBWriteData  formatted writeback value for the EX forwarding muxes
//
// Handshake: none. Every cycle is a valid writeback slot, qualified only by
// WBRegWrite. Reads never stall.
module wb_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        WBMemtoReg,
  input  logic        WBRegWrite,
  input  logic [3:0]  WBType,
  input  logic [4:0]  WBWriteReg,
  input  logic [31:0] WBResult,
  input  logic [31:0] WBReadDM,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] WBWriteData
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        wr_en;

  // Lane extraction: byte lane from WBResult[1:0], halfword lane from WBResult[1].
  always_comb begin
    load_byte = 8'h00;
    case (WBResult[1:0])
      2'd0: load_byte = WBReadDM[7:0];
      2'd1: load_byte = WBReadDM[15:8];
      2'd2: load_byte = WBReadDM[23:16];
      default: load_byte = WBReadDM[31:24];
    endcase
    load_half = WBResult[1] ? WBReadDM[31:16] : WBReadDM[15:0];
  end

  always_comb begin
    WBWriteData = WBResult;
    if (WBMemtoReg) begin
      case (WBType)
        4'd1:    WBWriteData = {{24{load_byte[7]}}, load_byte};
        4'd2:    WBWriteData = {24'h0, load_byte};
        4'd3:    WBWriteData = {{16{load_half[15]}}, load_half};
        4'd4:    WBWriteData = {16'h0, load_half};
        default: WBWriteData = WBReadDM;
      endcase
    end
  end

  // Writes to register 0 are dropped here, so regs_q[0] stays at its reset value.
  assign wr_en = WBRegWrite && (WBWriteReg != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[WBWriteReg] = WBWriteData;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 29) ? SP_INIT : 32'h0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write-through bypass gives decode zero-cycle read-after-write. wr_en
  // already excludes index 0, so a matching bypass implies a nonzero index.
  always_comb begin
    ReadData1 = 32'h0;
    ReadData2 = 32'h0;
    if (ReadReg1 != 5'd0) begin
      ReadData1 = (wr_en && (ReadReg1 == WBWriteReg)) ? WBWriteData : regs_q[ReadReg1];
    end
    if (ReadReg2 != 5'd0) begin
      ReadData2 = (wr_en && (ReadReg2 == WBWriteReg)) ? WBWriteData : regs_q[ReadReg2];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  localparam logic [31:0] SP_VAL = 32'h0000_3FFC;

  logic        Clk;
  logic        Reset;
  logic        WBMemtoReg;
  logic        WBRegWrite;
  logic [3:0]  WBType;
  logic [4:0]  WBWriteReg;
  logic [31:0] WBResult;
  logic [31:0] WBReadDM;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WBWriteData;

  int errors = 0;
  int checks = 0;

  wb_regfile #(.SP_INIT(SP_VAL)) dut (
    .Clk(Clk), .Reset(Reset), .WBMemtoReg(WBMemtoReg), .WBRegWrite(WBRegWrite),
    .WBType(WBType), .WBWriteReg(WBWriteReg), .WBResult(WBResult), .WBReadDM(WBReadDM),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WBWriteData(WBWriteData)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: the architectural register contents.
  logic [31:0] model [32];

  // Writeback value computed from the load-format rules with plain arithmetic.
  function automatic logic [31:0] fmt(input logic mtr, input logic [3:0] t,
                                      input logic [31:0] res, input logic [31:0] dm);
    logic [31:0] b;
    logic [31:0] h;
    b = (dm >> (8 * res[1:0])) & 32'hFF;
    h = (dm >> (16 * res[1])) & 32'hFFFF;
    if (!mtr) return res;
    case (t)
      4'd1: return (b > 127) ? (b | 32'hFFFF_FF00) : b;
      4'd2: return b;
      4'd3: return (h > 32767) ? (h | 32'hFFFF_0000) : h;
      4'd4: return h;
      default: return dm;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (WBRegWrite && WBWriteReg != 0 && idx == WBWriteReg)
      return fmt(WBMemtoReg, WBType, WBResult, WBReadDM);
    return model[idx];
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) model[i] <= (i == 29) ? SP_VAL : 32'h0;
    end else if (WBRegWrite && WBWriteReg != 0) begin
      model[WBWriteReg] <= fmt(WBMemtoReg, WBType, WBResult, WBReadDM);
    end
  end

  // Driver: inputs change on the falling edge (as MEM/WB does), and are
  // sampled 1 time unit later, well away from the rising commit edge.
  task automatic drive(input logic mtr, input logic wr, input logic [3:0] t,
                       input logic [4:0] wreg, input logic [31:0] res, input logic [31:0] dm,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge Clk);
    WBMemtoReg = mtr; WBRegWrite = wr; WBType = t; WBWriteReg = wreg;
    WBResult = res; WBReadDM = dm; ReadReg1 = r1; ReadReg2 = r2;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    WBMemtoReg = 0; WBRegWrite = 0; WBType = 0; WBWriteReg = 0;
    WBResult = 0; WBReadDM = 0; ReadReg1 = 0; ReadReg2 = 0;
    #2 Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 29, 5);
    checks++;
    if (ReadData1 !== SP_VAL) begin errors++; $display("FAIL reset_sp actual=%h required=%h", ReadData1, SP_VAL); end
    checks++;
    if (ReadData2 !== 32'h0) begin errors++; $display("FAIL reset_r5 actual=%h required=%h", ReadData2, 32'h0); end
    @(negedge Clk); Reset = 1'b1;
    drive(0, 1, 0, 5, 32'h1234, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    checks++;
    if (ReadData1 !== 32'h1234) begin errors++; $display("FAIL write_r5 actual=%h required=%h", ReadData1, 32'h1234); end
    // Reset mid-run with a pending write: contents clear, bypass still applies.
    @(negedge Clk); Reset = 1'b0;
    drive(0, 1, 0, 5, 32'h9999, 0, 29, 5);
    checks++;
    if (ReadData1 !== SP_VAL) begin errors++; $display("FAIL midreset_sp actual=%h required=%h", ReadData1, SP_VAL); end
    checks++;
    if (ReadData2 !== 32'h9999) begin errors++; $display("FAIL midreset_bypass actual=%h required=%h", ReadData2, 32'h9999); end
    drive(0, 0, 0, 0, 0, 0, 5, 29);
    checks++;
    if (ReadData1 !== 32'h0) begin errors++; $display("FAIL reset_no_commit actual=%h required=%h", ReadData1, 32'h0); end
    @(negedge Clk); Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 5, 29);
    checks++;
    if (ReadData1 !== 32'h0 || ReadData2 !== SP_VAL) begin
      errors++; $display("FAIL post_reset actual=%h/%h required=%h/%h", ReadData1, ReadData2, 32'h0, SP_VAL);
    end
  endtask

  task automatic test_zero();
    drive(0, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);
    checks++;
    if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
      errors++; $display("FAIL zero_during actual=%h/%h required=0", ReadData1, ReadData2);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ReadData1 !== 32'h0) begin errors++; $display("FAIL zero_after actual=%h required=0", ReadData1); end
  endtask

  task automatic test_load_format();
    logic [3:0]  t_tab [5];
    logic [31:0] a_tab [5];
    logic [31:0] e_tab [5];
    t_tab = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9};
    a_tab = '{32'd3, 32'd3, 32'd2, 32'd0, 32'd0};
    e_tab = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, t_tab[k], 10, a_tab[k], 32'h80FF_7F01, 10, 0);
      checks++;
      if (WBWriteData !== e_tab[k] || ReadData1 !== e_tab[k]) begin
        errors++;
        $display("FAIL load_fmt type=%0d wdata=%h rd1=%h required=%h", t_tab[k], WBWriteData, ReadData1, e_tab[k]);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 10, 0);
    checks++;
    if (ReadData1 !== 32'h80FF_7F01) begin errors++; $display("FAIL load_commit actual=%h required=%h", ReadData1, 32'h80FF_7F01); end
  endtask

  task automatic test_alu_path();
    drive(0, 1, 4'd1, 8, 32'hDEAD_BEEF, 32'h0000_0011, 0, 0);
    checks++;
    if (WBWriteData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_wdata actual=%h required=%h", WBWriteData, 32'hDEAD_BEEF); end
    drive(0, 0, 0, 0, 0, 0, 8, 0);
    checks++;
    if (ReadData1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_commit actual=%h required=%h", ReadData1, 32'hDEAD_BEEF); end
  endtask

  task automatic test_bypass();
    drive(0, 1, 0, 12, 32'h1, 0, 0, 0);
    drive(0, 0, 0, 12, 32'h55, 0, 12, 12);
    checks++;
    if (ReadData1 !== 32'h1 || ReadData2 !== 32'h1) begin
      errors++; $display("FAIL bypass_off actual=%h/%h required=1", ReadData1, ReadData2);
    end
    drive(0, 1, 0, 12, 32'h55, 0, 12, 12);
    checks++;
    if (ReadData1 !== 32'h55 || ReadData2 !== 32'h55) begin
      errors++; $display("FAIL bypass_on actual=%h/%h required=55", ReadData1, ReadData2);
    end
    drive(0, 0, 0, 0, 0, 0, 12, 12);
    checks++;
    if (ReadData1 !== 32'h55 || ReadData2 !== 32'h55) begin
      errors++; $display("FAIL bypass_commit actual=%h/%h required=55", ReadData1, ReadData2);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 0, 3, 32'hAAAA_0003, 0, 0, 0);
    drive(0, 1, 0, 4, 32'hBBBB_0004, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 3, 4);
    checks++;
    if (ReadData1 !== 32'hAAAA_0003 || ReadData2 !== 32'hBBBB_0004) begin
      errors++; $display("FAIL back_to_back actual=%h/%h required=aaaa0003/bbbb0004", ReadData1, ReadData2);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, ew;
    int rnd_err = 0;
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
            5'($urandom_range(0, 31)), $urandom, $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      e1 = exp_read(ReadReg1);
      e2 = exp_read(ReadReg2);
      ew = fmt(WBMemtoReg, WBType, WBResult, WBReadDM);
      checks++;
      if (ReadData1 !== e1 || ReadData2 !== e2 || WBWriteData !== ew) begin
        errors++;
        if (rnd_err < 10)
          $display("FAIL random cyc=%0d rd1=%h/%h rd2=%h/%h wdata=%h/%h (actual/required)",
                   n, ReadData1, e1, ReadData2, e2, WBWriteData, ew);
        rnd_err++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_load_format();
    test_alu_path();
    test_bypass();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
